// File: rtl/clock_pkg.sv
// Shared definitions for the hr/min/sec timekeeping path.
//  mode_t    : display/edit field select (RUN, SET_HR, SET_MIN, SET_SEC)
//  HR_W/MS_W : field widths; HR_MAX/MS_MAX : field ranges
//  wrap_step : +/-1 with wrap inside 0..vmax
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int HR_W = 5;
  localparam int MS_W = 6;
  localparam logic [HR_W-1:0] HR_MAX = 5'd23;
  localparam logic [MS_W-1:0] MS_MAX = 6'd59;

  // Out-of-range inputs snap back into range, so a stored field never
  // escapes 0..vmax even if the captured live value was bad.
  function automatic logic [MS_W-1:0] wrap_step(input logic [MS_W-1:0] v,
                                                input logic [MS_W-1:0] vmax,
                                                input logic            up);
    if (up) return (v >= vmax) ? '0 : v + 6'd1;
    else    return (v == '0 || v > vmax) ? vmax : v - 6'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles.
//  clk, rst_n : clock, async active-low reset
//  en         : run enable; counter and tick are cleared while low
//  tick       : registered strobe, high the cycle after count hits TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-time sequencer for the timekeeper: 1 Hz tick generation plus a
// button-driven FSM that edits a shadow hr/min/sec and commits it with ld.
//  clk, rst_n                 : clock, async active-low reset
//  btn_mode/btn_inc/btn_dec   : debounced 1-cycle button pulses
//  cur_hr/cur_min/cur_sec     : live time, captured on entry to SET_HR
//  tick                       : 1-cycle advance strobe (RUN only)
//  ld, ld_hr/ld_min/ld_sec    : 1-cycle commit strobe and edited time
//  mode                       : current field select (0=RUN .. 3=SET_SEC)
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int IDLE_CYC = 500_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_mode,
  input  logic            btn_inc,
  input  logic            btn_dec,
  input  logic [HR_W-1:0] cur_hr,
  input  logic [MS_W-1:0] cur_min,
  input  logic [MS_W-1:0] cur_sec,
  output logic            tick,
  output logic            ld,
  output logic [HR_W-1:0] ld_hr,
  output logic [MS_W-1:0] ld_min,
  output logic [MS_W-1:0] ld_sec,
  output logic [1:0]      mode
);

  localparam int            IW        = $clog2(IDLE_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

  mode_t           state, state_nxt;
  logic [IW-1:0]   idle, idle_nxt;
  logic            ld_nxt;
  logic [HR_W-1:0] hr_nxt;
  logic [MS_W-1:0] min_nxt, sec_nxt;

  logic any_btn, edit_up, edit_dn, edit, idle_exp, pre_en;

  assign any_btn = btn_mode | btn_inc | btn_dec;
  // mode beats inc/dec, and inc+dec cancel each other
  assign edit_up = btn_inc & ~btn_dec & ~btn_mode;
  assign edit_dn = btn_dec & ~btn_inc & ~btn_mode;
  assign edit    = edit_up | edit_dn;
  // any button on the expiry edge restarts the idle window instead
  assign idle_exp = (idle == IDLE_LAST) && !any_btn;

  // Enable looks at the edge's own decision: leaving RUN clears the
  // prescaler on that same edge so no tick leaks into a SET state, and
  // re-entering RUN starts from 0 on the following edge.
  assign pre_en = (state == RUN) && !btn_mode;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    ld_nxt    = 1'b0;
    hr_nxt    = ld_hr;
    min_nxt   = ld_min;
    sec_nxt   = ld_sec;
    case (state)
      RUN: begin
        if (btn_mode) begin
          state_nxt = SET_HR;
          hr_nxt    = cur_hr;
          min_nxt   = cur_min;
          sec_nxt   = cur_sec;
        end
      end
      SET_HR: begin
        if (btn_mode)      state_nxt = SET_MIN;
        else if (idle_exp) state_nxt = RUN;
        else if (edit)     hr_nxt = HR_W'(wrap_step({1'b0, ld_hr}, {1'b0, HR_MAX}, edit_up));
      end
      SET_MIN: begin
        if (btn_mode)      state_nxt = SET_SEC;
        else if (idle_exp) state_nxt = RUN;
        else if (edit)     min_nxt = wrap_step(ld_min, MS_MAX, edit_up);
      end
      SET_SEC: begin
        if (btn_mode) begin
          state_nxt = RUN;
          ld_nxt    = 1'b1;
        end else if (idle_exp) state_nxt = RUN;
        else if (edit)         sec_nxt = wrap_step(ld_sec, MS_MAX, edit_up);
      end
      default: state_nxt = RUN;
    endcase

    if (state == RUN || state_nxt != state || any_btn) idle_nxt = '0;
    else                                               idle_nxt = idle + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      idle   <= '0;
      ld     <= 1'b0;
      ld_hr  <= '0;
      ld_min <= '0;
      ld_sec <= '0;
    end else begin
      state  <= state_nxt;
      idle   <= idle_nxt;
      ld     <= ld_nxt;
      ld_hr  <= hr_nxt;
      ld_min <= min_nxt;
      ld_sec <= sec_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=4, IDLE_CYC=16.
module tb_clock_set_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hr = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       tick, ld;
  logic [4:0] ld_hr;
  logic [5:0] ld_min, ld_sec;
  logic [1:0] mode;

  int checks = 0, errors = 0;

  clock_set_ctrl #(.TICK_DIV(4), .IDLE_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
    .tick(tick), .ld(ld), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
    .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ld(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    chk({tag, "_hr"},  ld_hr,  h);
    chk({tag, "_min"}, ld_min, m);
    chk({tag, "_sec"}, ld_sec, s);
  endtask

  // one clock with the given buttons held, then release; outputs settled on return
  task automatic cyc(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_tick", tick, 0);
    chk("rst_ld", ld, 0);
    chk("rst_mode", mode, 0);
    chk_ld("rst", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: ticks on cycles 4, 8, 12
    for (int k = 1; k <= 13; k++) begin
      cyc(0, 0, 0);
      chk("t1_tick", tick, (k % 4 == 0));
      chk("t1_ld", ld, 0);
      chk("t1_mode", mode, 0);
    end

    // 2: 23:59:58 -> 00:58:59
    cur_hr = 5'd23; cur_min = 6'd59; cur_sec = 6'd58;
    cyc(1, 0, 0); chk("t2_mode1", mode, 1); chk_ld("t2_cap", 23, 59, 58); chk("t2_tick", tick, 0);
    cyc(0, 1, 0); chk("t2_hrinc", ld_hr, 0);
    cyc(1, 0, 0); chk("t2_mode2", mode, 2);
    cyc(0, 0, 1); chk("t2_mindec", ld_min, 58);
    cyc(1, 0, 0); chk("t2_mode3", mode, 3);
    cyc(0, 1, 0); chk("t2_secinc", ld_sec, 59);
    cyc(1, 0, 0); chk("t2_ld", ld, 1); chk("t2_mode0", mode, 0); chk("t2_ldtick", tick, 0);
    chk_ld("t2_commit", 0, 58, 59);
    cyc(0, 0, 0); chk("t2_ldoff", ld, 0); chk_ld("t2_hold", 0, 58, 59);
    cyc(0, 1, 0); chk("t2_runinc_ld", ld, 0); chk_ld("t2_runinc", 0, 58, 59);

    // 3: wrap at zero
    cur_hr = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
    cyc(1, 0, 0); chk("t3_mode1", mode, 1); chk("t3_cap", ld_hr, 0);
    cyc(0, 0, 1); chk("t3_hrdec", ld_hr, 23);
    cyc(0, 1, 0); chk("t3_hrinc1", ld_hr, 0);
    cyc(0, 1, 0); chk("t3_hrinc2", ld_hr, 1);
    cyc(1, 0, 0); chk("t3_mode2", mode, 2);
    cyc(0, 0, 1); chk("t3_mindec", ld_min, 59);
    cyc(1, 0, 0); chk("t3_mode3", mode, 3);
    cyc(1, 0, 0); chk("t3_ld", ld, 1); chk_ld("t3_commit", 1, 59, 0);

    // 4: idle abort from SET_MIN, tick resumes 4 cycles later
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); chk("t4_mode2", mode, 2);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 0);
      chk("t4_mode", mode, (k == 16) ? 0 : 2);
      chk("t4_ld", ld, 0);
      chk("t4_tick", tick, 0);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0);
      chk("t4_resume", tick, (k == 4));
      chk("t4_ld2", ld, 0);
    end

    // 5: inc+dec cancel, mode+inc commits without edit
    cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    chk("t5_mode3", mode, 3); chk("t5_cap", ld_sec, 56);
    cyc(0, 1, 1); chk("t5_both", ld_sec, 56); chk("t5_both_mode", mode, 3);
    cyc(1, 1, 0); chk("t5_mode0", mode, 0); chk("t5_ld", ld, 1);
    chk_ld("t5_commit", 12, 34, 56);

    // 6: reset mid-edit
    cur_hr = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0); chk("t6_mininc", ld_min, 21); chk("t6_mode2", mode, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mode", mode, 0); chk("t6_ld", ld, 0); chk("t6_tick", tick, 0);
    chk_ld("t6_rst", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0);
      chk("t6_post_ld", ld, 0);
      chk("t6_post_mode", mode, 0);
      chk("t6_post_tick", tick, (k % 4 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
